dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port 32-bit data memory with a request/ack handshake
// and a configurable number of wait states before each response.
//
// A request (data_we | data_re) is accepted only while idle (data_ready = 1).
// After WAIT_CYCLES further edges the memory access happens. data_ack pulses
// for the one cycle that follows that access, carrying data_rdata/data_err.
// A request that sets both data_we and data_re is a write.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words (power of two, 16..4096)
//   WAIT_CYCLES - wait states before each response (0..15)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (memory contents are kept)
//   data_addr  - byte address; word index is data_addr[log2(DEPTH_WORDS)+1:2]
//   data_wdata - write data
//   data_we    - write request
//   data_re    - read request
//   data_ready - idle, a request will be accepted at the next edge
//   data_ack   - one-cycle response pulse
//   data_rdata - read data during a read ack, 0 otherwise
//   data_err   - error response during ack, 0 otherwise
//
// Build option:
//   DMEM_RESPONDER_ERR_EN - when defined, misaligned or out-of-range addresses
//   complete with data_err = 1, data_rdata = 0 and leave memory untouched.
//   When undefined, data_err is 0 and upper address bits alias.

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_we,
    input  logic        data_re,
    output logic        data_ready,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;

    logic [31:0] mem [DEPTH_WORDS];

    // The access may happen on the accepting edge itself (WAIT_CYCLES = 0),
    // so the operation is taken from the live inputs while idle and from the
    // latched copy afterwards.
    logic            accept;
    logic            enter_resp;
    logic [31:0]     cur_addr;
    logic [31:0]     cur_wdata;
    logic            cur_write;
    logic [IdxW-1:0] cur_idx;
    logic            cur_err;
    logic            mem_we;
    logic            unused_addr_bits;

    always_comb begin
        accept     = (state == StIdle) && (data_we || data_re);
        cur_addr   = (state == StIdle) ? data_addr : addr_q;
        cur_wdata  = (state == StIdle) ? data_wdata : wdata_q;
        cur_write  = (state == StIdle) ? data_we : write_q;
        cur_idx    = cur_addr[IdxW+1:2];
        enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state == StWait) && (wait_cnt == 4'd1));
    end

`ifdef DMEM_RESPONDER_ERR_EN
    always_comb begin
        cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr >= 32'(DEPTH_WORDS * 4));
    end
`else
    always_comb begin
        cur_err = 1'b0;
    end
`endif

    // Bits outside the word index only matter for the error check.
    assign unused_addr_bits = ^{cur_addr[31:IdxW+2], cur_addr[1:0]};

    // A reset edge never commits a write, so an aborted write is dropped.
    assign mem_we = enter_resp && cur_write && !cur_err && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            wait_cnt   <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            data_ready <= 1'b1;
            data_ack   <= 1'b0;
            data_rdata <= 32'd0;
            data_err   <= 1'b0;
        end else begin
            data_ack   <= 1'b0;
            data_rdata <= 32'd0;
            data_err   <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (accept) begin
                        addr_q     <= data_addr;
                        wdata_q    <= data_wdata;
                        write_q    <= data_we;
                        data_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= StResp;
                        end else begin
                            state    <= StWait;
                            wait_cnt <= WaitInit;
                        end
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= StResp;
                    end
                end
                StResp: begin
                    state      <= StIdle;
                    data_ready <= 1'b1;
                end
                default: begin
                    state      <= StIdle;
                    data_ready <= 1'b1;
                end
            endcase

            // Registered read: response outputs are loaded on the edge that
            // enters the response cycle.
            if (enter_resp) begin
                data_ack <= 1'b1;
                data_err <= cur_err;
                if (!cur_write && !cur_err) begin
                    data_rdata <= mem[cur_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES = 1, index 1: WAIT_CYCLES = 0
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        we_v    [2];
    logic        re_v    [2];
    logic        ready_o [2];
    logic        ack_o   [2];
    logic        err_o   [2];
    logic [31:0] rdata_o [2];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk        (clk),
        .rst        (rst),
        .data_addr  (addr_v[0]),
        .data_wdata (wdata_v[0]),
        .data_we    (we_v[0]),
        .data_re    (re_v[0]),
        .data_ready (ready_o[0]),
        .data_ack   (ack_o[0]),
        .data_rdata (rdata_o[0]),
        .data_err   (err_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk        (clk),
        .rst        (rst),
        .data_addr  (addr_v[1]),
        .data_wdata (wdata_v[1]),
        .data_we    (we_v[1]),
        .data_re    (re_v[1]),
        .data_ready (ready_o[1]),
        .data_ack   (ack_o[1]),
        .data_rdata (rdata_o[1]),
        .data_err   (err_o[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_RESPONDER_ERR_EN
        return ((a % 4) != 0) || (a >= DEPTH * 4);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Transaction-level model: a request accepted at edge k is answered on
    // edge k + wait, acked in the following cycle, and the block is idle
    // again from edge k + wait + 1.
    logic [31:0] mem_m     [2][DEPTH];
    bit          known_m   [2][DEPTH];
    bit          busy_m    [2];
    int          resp_edge [2];
    bit          req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    bit          exp_ack   [2];
    bit          exp_err   [2];
    bit          exp_ready [2];
    bit          exp_known [2];
    logic [31:0] exp_rdata [2];
    int          edge_n = 0;
    bit          was_busy;
    int          idx;

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            exp_ack[i]   = 1'b0;
            exp_err[i]   = 1'b0;
            exp_rdata[i] = 32'd0;
            exp_known[i] = 1'b1;
            if (rst) begin
                busy_m[i] = 1'b0;
            end else begin
                was_busy = busy_m[i];
                if (busy_m[i] && edge_n == resp_edge[i] + 1) busy_m[i] = 1'b0;
                if (!was_busy && (we_v[i] || re_v[i])) begin
                    busy_m[i]    = 1'b1;
                    resp_edge[i] = edge_n + wait_of(i);
                    req_we[i]    = we_v[i];
                    req_addr[i]  = addr_v[i];
                    req_wdata[i] = wdata_v[i];
                end
                if (busy_m[i] && edge_n == resp_edge[i]) begin
                    idx        = int'((req_addr[i] / 4) % DEPTH);
                    exp_ack[i] = 1'b1;
                    exp_err[i] = addr_err(req_addr[i]);
                    if (!exp_err[i]) begin
                        if (req_we[i]) begin
                            mem_m[i][idx]   = req_wdata[i];
                            known_m[i][idx] = 1'b1;
                        end else begin
                            exp_rdata[i] = mem_m[i][idx];
                            exp_known[i] = known_m[i][idx];
                        end
                    end
                end
            end
            exp_ready[i] = !busy_m[i];
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d ready @edge %0d", i, edge_n), 32'(ready_o[i]), 32'(exp_ready[i]));
            check($sformatf("u%0d ack @edge %0d", i, edge_n), 32'(ack_o[i]), 32'(exp_ack[i]));
            check($sformatf("u%0d err @edge %0d", i, edge_n), 32'(err_o[i]), 32'(exp_err[i]));
            if (exp_known[i]) begin
                check($sformatf("u%0d rdata @edge %0d", i, edge_n), rdata_o[i], exp_rdata[i]);
            end
        end
    end

    // Drives one request for a single cycle and waits (bounded) for its ack.
    // lat counts cycles after acceptance; low counts cycles with ready = 0.
    task automatic do_req(input int i, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int low);
        @(negedge clk);
        we_v[i] = we; re_v[i] = re; addr_v[i] = a; wdata_v[i] = wd;
        lat = 0; low = 0; rd = 32'd0; er = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            we_v[i] = 1'b0; re_v[i] = 1'b0;
            if (!ready_o[i]) low++;
            if (ack_o[i]) begin
                lat = n; rd = rdata_o[i]; er = err_o[i];
                break;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL ack timeout u%0d addr %h: got no ack, expected one within 20 cycles", i, a);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          low;
    int          acks;

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = 32'd0; wdata_v[i] = 32'd0; we_v[i] = 1'b0; re_v[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset ready u%0d", i), 32'(ready_o[i]), 32'd1);
            check($sformatf("reset ack u%0d", i), 32'(ack_o[i]), 32'd0);
            check($sformatf("reset rdata u%0d", i), rdata_o[i], 32'd0);
            check($sformatf("reset err u%0d", i), 32'(err_o[i]), 32'd0);
        end
        rst = 1'b0;

        // Basic write then read, one wait state
        do_req(0, 1'b1, 1'b0, 32'h30, 32'hA5A5_A5A5, rd, er, lat, low);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, low);
        check("write latency", 32'(lat), 32'd2);
        check("write ack rdata", rd, 32'd0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'd0, rd, er, lat, low);
        check("read latency", 32'(lat), 32'd2);
        check("read data 0x10", rd, 32'hDEAD_BEEF);
        check("ready low cycles", 32'(low), 32'd2);

        // we and re together act as a write
        do_req(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, rd, er, lat, low);
        check("we+re ack rdata", rd, 32'd0);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'd0, rd, er, lat, low);
        check("read data 0x20", rd, 32'h1234_5678);

        // Write presented during WAIT and RESP is ignored
        @(negedge clk);
        re_v[0] = 1'b1; addr_v[0] = 32'h20;
        @(negedge clk);
        re_v[0] = 1'b0; we_v[0] = 1'b1; addr_v[0] = 32'h10; wdata_v[0] = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        we_v[0] = 1'b0;
        do_req(0, 1'b0, 1'b1, 32'h10, 32'd0, rd, er, lat, low);
        check("ignored write 0x10", rd, 32'hDEAD_BEEF);

        // Reset during WAIT aborts the write
        @(negedge clk);
        we_v[0] = 1'b1; addr_v[0] = 32'h30; wdata_v[0] = 32'h1111_1111;
        @(negedge clk);
        we_v[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", 32'(ready_o[0]), 32'd1);
        check("abort ack", 32'(ack_o[0]), 32'd0);
        @(negedge clk);
        check("abort no late ack", 32'(ack_o[0]), 32'd0);
        do_req(0, 1'b0, 1'b1, 32'h30, 32'd0, rd, er, lat, low);
        check("aborted write 0x30", rd, 32'hA5A5_A5A5);

`ifdef DMEM_RESPONDER_ERR_EN
        do_req(0, 1'b0, 1'b1, 32'h13, 32'd0, rd, er, lat, low);
        check("misaligned err", 32'(er), 32'd1);
        check("misaligned rdata", rd, 32'd0);
        do_req(0, 1'b0, 1'b1, 32'h400, 32'd0, rd, er, lat, low);
        check("range err", 32'(er), 32'd1);
        check("range rdata", rd, 32'd0);
        check("range latency", 32'(lat), 32'd2);
`else
        do_req(0, 1'b0, 1'b1, 32'h410, 32'd0, rd, er, lat, low);
        check("alias 0x410 data", rd, 32'hDEAD_BEEF);
        check("alias 0x410 err", 32'(er), 32'd0);
`endif

        // Zero wait states
        do_req(1, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, rd, er, lat, low);
        check("w0 write latency", 32'(lat), 32'd1);
        do_req(1, 1'b0, 1'b1, 32'h10, 32'd0, rd, er, lat, low);
        check("w0 read latency", 32'(lat), 32'd1);
        check("w0 read data", rd, 32'hCAFE_F00D);

        // Held request: one ack every second cycle
        @(negedge clk);
        re_v[1] = 1'b1; addr_v[1] = 32'h10;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_o[1]) acks++;
        end
        re_v[1] = 1'b0;
        check("w0 back-to-back acks", 32'(acks), 32'd4);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
